// File: rtl/prefetch_request_sink.sv
// Filters prefetch addresses (out-of-grid / recent duplicates), queues survivors, issues over req/ack.
// Latency: accept at edge N -> mem_req after edge N+1; in_ready drops only when the FIFO is full.
module prefetch_request_sink #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int HIST_DEPTH = 8,
    parameter int GRID_SIZE  = 27
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hist_clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [15:0]       issued_cnt,
    output logic [15:0]       dropped_cnt,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HIST_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;
    state_t state;

    logic [ADDR_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic [ADDR_W-1:0]     hist_addr [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_valid;
    logic [HW-1:0]         hist_ptr;

    logic accept;
    logic out_of_grid;
    logic hist_hit;
    logic enq;
    logic drop;
    logic pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign in_ready   = !fifo_full;
    assign busy       = !fifo_empty || (state == REQ);

    // A coincident hist_clear wins, so the lookup sees an empty history.
    always_comb begin
        hist_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_valid[i] && (hist_addr[i] == in_addr)) begin
                hist_hit = 1'b1;
            end
        end
        hist_hit = hist_hit && !hist_clear;
    end

    assign accept      = in_valid && in_ready;
    assign out_of_grid = (in_addr >= ADDR_W'(GRID_SIZE));
    assign drop        = accept && (out_of_grid || hist_hit);
    assign enq         = accept && !out_of_grid && !hist_hit;
    assign pop         = !fifo_empty && ((state == IDLE) || ((state == REQ) && mem_ack));

    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_mem[wr_ptr[PW-1:0]] <= in_addr;
            hist_addr[hist_ptr]      <= in_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hist_valid  <= '0;
            hist_ptr    <= '0;
            dropped_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            if (hist_clear && enq) begin
                hist_valid <= {{(HIST_DEPTH-1){1'b0}}, 1'b1} << hist_ptr;
            end else if (hist_clear) begin
                hist_valid <= '0;
            end else if (enq) begin
                hist_valid[hist_ptr] <= 1'b1;
            end
            if (enq) begin
                hist_ptr <= (hist_ptr == HW'(HIST_DEPTH-1)) ? '0 : hist_ptr + HW'(1);
            end
            if (drop && (dropped_cnt != 16'hFFFF)) begin
                dropped_cnt <= dropped_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            issued_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        mem_addr <= fifo_mem[rd_ptr[PW-1:0]];
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (issued_cnt != 16'hFFFF) begin
                            issued_cnt <= issued_cnt + 16'd1;
                        end
                        // Back-to-back issue keeps mem_req high with no idle cycle.
                        if (pop) begin
                            mem_addr <= fifo_mem[rd_ptr[PW-1:0]];
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_request_sink.sv
module tb_prefetch_request_sink;

    logic        clock;
    logic        reset;
    logic [31:0] in_addr;
    logic        in_valid;
    logic        in_ready;
    logic        hist_clear;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] issued_cnt;
    logic [15:0] dropped_cnt;
    logic        busy;

    int total;
    int bad;

    prefetch_request_sink #(
        .ADDR_W(32), .FIFO_DEPTH(4), .HIST_DEPTH(8), .GRID_SIZE(27)
    ) dut (
        .clock(clock), .reset(reset),
        .in_addr(in_addr), .in_valid(in_valid), .in_ready(in_ready),
        .hist_clear(hist_clear),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
        .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        hist_clear = 1'b0;
        mem_ack    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; hist_clear = 1'b0; mem_ack = 1'b0;
        #2;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        chk("rst_dropped", {16'd0, dropped_cnt}, 32'd0);

        // Streaming 4,5,7 with ack tied high
        do_reset();
        mem_ack = 1'b1;
        in_valid = 1'b1; in_addr = 32'd4; tick();
        chk("s1_req_lat", {31'd0, mem_req}, 32'd0);
        in_addr = 32'd5; tick();
        chk("s1_addr4", mem_addr, 32'd4);
        chk("s1_req4", {31'd0, mem_req}, 32'd1);
        in_addr = 32'd7; tick();
        chk("s1_addr5", mem_addr, 32'd5);
        in_valid = 1'b0; tick();
        chk("s1_addr7", mem_addr, 32'd7);
        chk("s1_req7", {31'd0, mem_req}, 32'd1);
        tick();
        chk("s1_req_end", {31'd0, mem_req}, 32'd0);
        chk("s1_issued", {16'd0, issued_cnt}, 32'd3);
        chk("s1_dropped", {16'd0, dropped_cnt}, 32'd0);
        chk("s1_busy", {31'd0, busy}, 32'd0);

        // Out-of-grid: 30 and 27 dropped, 26 issued
        do_reset();
        mem_ack = 1'b1;
        in_valid = 1'b1; in_addr = 32'd30; tick();
        chk("s2_drop30", {16'd0, dropped_cnt}, 32'd1);
        chk("s2_busy30", {31'd0, busy}, 32'd0);
        in_addr = 32'd27; tick();
        chk("s2_drop27", {16'd0, dropped_cnt}, 32'd2);
        in_addr = 32'd26; tick();
        in_valid = 1'b0; tick();
        chk("s2_addr26", mem_addr, 32'd26);
        chk("s2_req26", {31'd0, mem_req}, 32'd1);
        tick();
        chk("s2_issued", {16'd0, issued_cnt}, 32'd1);
        chk("s2_dropped", {16'd0, dropped_cnt}, 32'd2);

        // Duplicate filter and history clear coincident with accept
        do_reset();
        mem_ack = 1'b1;
        in_valid = 1'b1; in_addr = 32'd13; tick();
        tick();
        chk("s3_dup_drop", {16'd0, dropped_cnt}, 32'd1);
        chk("s3_addr13a", mem_addr, 32'd13);
        hist_clear = 1'b1; tick();
        hist_clear = 1'b0; in_valid = 1'b0;
        chk("s3_gap_req", {31'd0, mem_req}, 32'd0);
        chk("s3_issued1", {16'd0, issued_cnt}, 32'd1);
        tick();
        chk("s3_req13b", {31'd0, mem_req}, 32'd1);
        chk("s3_addr13b", mem_addr, 32'd13);
        tick();
        chk("s3_issued2", {16'd0, issued_cnt}, 32'd2);
        chk("s3_dropped1", {16'd0, dropped_cnt}, 32'd1);
        in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("s3_redrop", {16'd0, dropped_cnt}, 32'd2);
        tick();
        chk("s3_issued_final", {16'd0, issued_cnt}, 32'd2);

        // Backpressure: ack held low, 5 addresses fill FIFO plus outstanding
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("s4_ready_pre", {31'd0, in_ready}, 32'd1);
            in_addr = 32'd10 + i;
            tick();
        end
        chk("s4_ready_full", {31'd0, in_ready}, 32'd0);
        in_addr = 32'd15; tick();
        chk("s4_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("s4_addr_hold", mem_addr, 32'd10);
        chk("s4_busy", {31'd0, busy}, 32'd1);
        chk("s4_nodrop", {16'd0, dropped_cnt}, 32'd0);
        in_valid = 1'b0; mem_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("s4_order", mem_addr, 32'd10 + i);
        end
        chk("s4_ready_rel", {31'd0, in_ready}, 32'd1);
        tick();
        chk("s4_req_end", {31'd0, mem_req}, 32'd0);
        chk("s4_issued", {16'd0, issued_cnt}, 32'd5);

        // Asynchronous reset with a request outstanding and 2 queued
        do_reset();
        in_valid = 1'b1; in_addr = 32'd40; tick();
        in_addr = 32'd20; tick();
        in_addr = 32'd21; tick();
        in_addr = 32'd22; tick();
        in_valid = 1'b0;
        chk("s5_req_pre", {31'd0, mem_req}, 32'd1);
        chk("s5_drop_pre", {16'd0, dropped_cnt}, 32'd1);
        reset = 1'b1;
        #1;
        chk("s5_req_async", {31'd0, mem_req}, 32'd0);
        chk("s5_busy_async", {31'd0, busy}, 32'd0);
        chk("s5_drop_async", {16'd0, dropped_cnt}, 32'd0);
        chk("s5_addr_async", mem_addr, 32'd0);
        tick();
        reset = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s5_no_req", {31'd0, mem_req}, 32'd0);
        end
        chk("s5_issued", {16'd0, issued_cnt}, 32'd0);

        // History wrap: 0..7 fill it, 8 evicts 0, so 0 re-issues
        do_reset();
        mem_ack = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_addr = i;
            tick();
        end
        in_addr = 32'd0; tick();
        in_valid = 1'b0; tick();
        chk("s6_addr0", mem_addr, 32'd0);
        chk("s6_req0", {31'd0, mem_req}, 32'd1);
        tick();
        chk("s6_issued", {16'd0, issued_cnt}, 32'd10);
        chk("s6_dropped", {16'd0, dropped_cnt}, 32'd0);
        in_valid = 1'b1; in_addr = 32'd2; tick();
        in_valid = 1'b0;
        chk("s6_drop2", {16'd0, dropped_cnt}, 32'd1);
        tick();
        chk("s6_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
